// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

   localparam int PC_W = 64;

   // Stage indices into the per-stage control bundle.
   localparam int STG_F   = 0;
   localparam int STG_D   = 1;
   localparam int STG_E   = 2;
   localparam int STG_M   = 3;
   localparam int STG_W   = 4;
   localparam int STG_NUM = 5;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic stall;
      logic flush;
   } pipe_ctl_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/status inputs and per-stage control outputs of the sequencer.
// master: the pipeline datapath; slave: pipeline_ctrl.
interface pipeline_ctrl_if #(
   parameter int CNT_W = 64,
   parameter int REG_W = 5
);
   import pipeline_ctrl_pkg::*;

   logic              i_busy;
   logic              d_busy;
   logic              exe_busy;
   logic              jumpD;
   logic [PC_W-1:0]   pcsrcD;
   logic [REG_W-1:0]  ra1D;
   logic [REG_W-1:0]  ra2D;
   logic [REG_W-1:0]  dstE;
   logic              memreadE;

   logic              stallF;
   logic              stallD;
   logic              stallE;
   logic              stallM;
   logic              flushD;
   logic              flushE;
   logic              flushM;
   logic              flushW;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output i_busy, d_busy, exe_busy, jumpD, pcsrcD, ra1D, ra2D, dstE, memreadE,
      input  stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
      input  redirect_valid, redirect_pc, stall_cnt, flush_cnt
   );

   modport slave (
      input  i_busy, d_busy, exe_busy, jumpD, pcsrcD, ra1D, ra2D, dstE, memreadE,
      output stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
      output redirect_valid, redirect_pc, stall_cnt, flush_cnt
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detect: the E-stage load writes a register that decode reads.
// x0 is never a real dependency.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic             memreadE,
   input  logic [REG_W-1:0] dstE,
   input  logic [REG_W-1:0] ra1D,
   input  logic [REG_W-1:0] ra2D,
   output logic             lu
);

   // Combinational source/destination compare.
   always_comb begin
      lu = memreadE && (dstE != '0) && ((dstE == ra1D) || (dstE == ra2D));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the F/D/E/M/W pipeline.
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal flow; a decode jump redirects fetch at once if it is idle
// PEND  | jump seen while fetch was busy; pend_pc waits for fetch to finish
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 64,
   parameter int REG_W = 5
) (
   input  logic            clk,
   input  logic            reset,
   pipeline_ctrl_if.slave  bus
);

   ctrl_state_t       state;
   ctrl_state_t       state_nxt;
   logic [PC_W-1:0]   pend_pc;
   logic [PC_W-1:0]   pend_pc_nxt;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;
   pipe_ctl_t         ctl [STG_NUM];
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              lu;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .memreadE (bus.memreadE),
      .dstE     (bus.dstE),
      .ra1D     (bus.ra1D),
      .ra2D     (bus.ra2D),
      .lu       (lu)
   );

   // Priority resolution of stalls/bubbles and next-state for the redirect FSM.
   // Outputs are forced quiet while reset is asserted.
   always_comb begin
      for (int s = 0; s < STG_NUM; s++) begin
         ctl[s] = '0;
      end
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      state_nxt      = state;
      pend_pc_nxt    = pend_pc;

      if (reset) begin
         state_nxt = RUN;
      end else if (bus.d_busy) begin
         ctl[STG_F].stall = 1'b1;
         ctl[STG_D].stall = 1'b1;
         ctl[STG_E].stall = 1'b1;
         ctl[STG_M].stall = 1'b1;
         ctl[STG_W].flush = 1'b1;
      end else if (bus.exe_busy) begin
         ctl[STG_F].stall = 1'b1;
         ctl[STG_D].stall = 1'b1;
         ctl[STG_E].stall = 1'b1;
         ctl[STG_M].flush = 1'b1;
      end else if (lu) begin
         // Jump is dropped here; decode re-resolves it once the load forwards.
         ctl[STG_F].stall = 1'b1;
         ctl[STG_D].stall = 1'b1;
         ctl[STG_E].flush = 1'b1;
      end else begin
         ctl[STG_F].stall = bus.i_busy;
         unique case (state)
            RUN: begin
               if (bus.jumpD) begin
                  ctl[STG_D].flush = 1'b1;
                  if (bus.i_busy) begin
                     // Fetch cannot be retargeted mid-request; park the target.
                     pend_pc_nxt = bus.pcsrcD;
                     state_nxt   = PEND;
                  end else begin
                     redirect_valid = 1'b1;
                     redirect_pc    = bus.pcsrcD;
                  end
               end else if (bus.i_busy) begin
                  ctl[STG_D].flush = 1'b1;
               end
            end
            PEND: begin
               // D holds a bubble in PEND, so jumpD is meaningless here.
               ctl[STG_D].flush = 1'b1;
               if (!bus.i_busy) begin
                  redirect_valid = 1'b1;
                  redirect_pc    = pend_pc;
                  state_nxt      = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // FSM state, parked target and performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         pend_pc   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         pend_pc   <= pend_pc_nxt;
         stall_cnt <= stall_cnt + CNT_W'(ctl[STG_D].stall);
         flush_cnt <= flush_cnt + CNT_W'(redirect_valid);
      end
   end

   assign bus.stallF         = ctl[STG_F].stall;
   assign bus.stallD         = ctl[STG_D].stall;
   assign bus.stallE         = ctl[STG_E].stall;
   assign bus.stallM         = ctl[STG_M].stall;
   assign bus.flushD         = ctl[STG_D].flush;
   assign bus.flushE         = ctl[STG_E].flush;
   assign bus.flushM         = ctl[STG_M].flush;
   assign bus.flushW         = ctl[STG_W].flush;
   assign bus.redirect_valid = redirect_valid;
   assign bus.redirect_pc    = redirect_pc;
   assign bus.stall_cnt      = stall_cnt;
   assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: each vector pushes its expected response,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

   logic clk;
   logic reset;

   pipeline_ctrl_if #(.CNT_W(64), .REG_W(5)) bus ();

   pipeline_ctrl #(.CNT_W(64), .REG_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl bit order: {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, redirect_valid}
   typedef struct {
      logic [8:0]  ctl;
      logic [63:0] pc;
      logic [63:0] sc;
      logic [63:0] fc;
      string       name;
   } exp_t;

   exp_t        q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] exp_sc   = 64'd0;
   logic [63:0] exp_fc   = 64'd0;

   task automatic vec(input string name, input logic rst, input logic ib, input logic db,
                      input logic eb, input logic jd, input logic [63:0] pc,
                      input logic mr, input logic [4:0] dst, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [8:0] ectl, input logic [63:0] epc);
      exp_t e;
      @(posedge clk);
      #1;
      reset        = rst;
      bus.i_busy   = ib;
      bus.d_busy   = db;
      bus.exe_busy = eb;
      bus.jumpD    = jd;
      bus.pcsrcD   = pc;
      bus.memreadE = mr;
      bus.dstE     = dst;
      bus.ra1D     = r1;
      bus.ra2D     = r2;
      e.ctl  = ectl;
      e.pc   = epc;
      e.sc   = exp_sc;
      e.fc   = exp_fc;
      e.name = name;
      q.push_back(e);
      if (rst) begin
         exp_sc = 64'd0;
         exp_fc = 64'd0;
      end else begin
         exp_sc = exp_sc + 64'(ectl[7]);
         exp_fc = exp_fc + 64'(ectl[0]);
      end
   endtask

   task automatic idle(input string name);
      vec(name, 0, 0, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b000000000, 64'd0);
   endtask

   // Monitor: compare the presented response against the oldest expectation.
   always @(negedge clk) begin
      exp_t        e;
      logic [8:0]  act;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                bus.flushD, bus.flushE, bus.flushM, bus.flushW, bus.redirect_valid};
         n_checks++;
         if (act !== e.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
         end
         n_checks++;
         if (bus.redirect_pc !== e.pc) begin
            n_fail++;
            $display("FAIL %s redirect_pc: got %h expected %h", e.name, bus.redirect_pc, e.pc);
         end
         n_checks++;
         if (bus.stall_cnt !== e.sc) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, bus.stall_cnt, e.sc);
         end
         n_checks++;
         if (bus.flush_cnt !== e.fc) begin
            n_fail++;
            $display("FAIL %s flush_cnt: got %0d expected %0d", e.name, bus.flush_cnt, e.fc);
         end
      end
   end

   initial begin
      reset        = 1'b1;
      bus.i_busy   = 1'b0;
      bus.d_busy   = 1'b0;
      bus.exe_busy = 1'b0;
      bus.jumpD    = 1'b0;
      bus.pcsrcD   = 64'd0;
      bus.memreadE = 1'b0;
      bus.dstE     = 5'd0;
      bus.ra1D     = 5'd0;
      bus.ra2D     = 5'd0;

      // Reset: outputs quiet even with hazards and a jump presented.
      vec("rst0", 1, 0, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b000000000, 64'd0);
      vec("rst1", 1, 1, 1, 0, 1, 64'h8000_0aaa, 1, 5'd5, 5'd5, 5'd0, 9'b000000000, 64'd0);
      idle("idle0");

      // Load-use on either source; jumpD ignored under load-use; x0 and non-loads ignored.
      vec("lu_ra1", 0, 0, 0, 0, 0, 64'd0, 1, 5'd5, 5'd5, 5'd0, 9'b110001000, 64'd0);
      vec("lu_ra2_jmp", 0, 0, 0, 0, 1, 64'h1234, 1, 5'd7, 5'd3, 5'd7, 9'b110001000, 64'd0);
      vec("lu_dst0", 0, 0, 0, 0, 0, 64'd0, 1, 5'd0, 5'd0, 5'd0, 9'b000000000, 64'd0);
      vec("no_load", 0, 0, 0, 0, 0, 64'd0, 0, 5'd5, 5'd5, 5'd0, 9'b000000000, 64'd0);

      // Immediate redirect from RUN.
      vec("jmp_run", 0, 0, 0, 0, 1, 64'h8000_0040, 0, 5'd0, 5'd0, 5'd0, 9'b000010001, 64'h8000_0040);
      idle("post_jmp");

      // Jump while fetch busy: PEND for 3 cycles, then a single redirect.
      vec("pend_enter", 0, 1, 0, 0, 1, 64'h8000_0100, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);
      vec("pend_wait1", 0, 1, 0, 0, 1, 64'hdead_beef, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);
      vec("pend_wait2", 0, 1, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);
      vec("pend_fire", 0, 0, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b000010001, 64'h8000_0100);
      idle("pend_once");

      // d_busy overrides PEND: no redirect until it drops.
      vec("pd_enter", 0, 1, 0, 0, 1, 64'h8000_0200, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);
      vec("pd_dbusy1", 0, 0, 1, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b111100010, 64'd0);
      vec("pd_dbusy2", 0, 0, 1, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b111100010, 64'd0);
      vec("pd_fire", 0, 0, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b000010001, 64'h8000_0200);
      idle("pd_once");

      // exe_busy wins over load-use for 4 cycles, then load-use resolves.
      for (int i = 0; i < 4; i++) begin
         vec($sformatf("exe_lu%0d", i), 0, 0, 0, 1, 0, 64'd0, 1, 5'd9, 5'd9, 5'd0,
             9'b111000100, 64'd0);
      end
      vec("lu_after", 0, 0, 0, 0, 0, 64'd0, 1, 5'd9, 5'd9, 5'd0, 9'b110001000, 64'd0);
      idle("idle2");

      // Fetch busy without a jump: bubble into D.
      vec("ibusy_bubble", 0, 1, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);

      // Reset in PEND discards the parked target.
      vec("rp_enter", 0, 1, 0, 0, 1, 64'h8000_0300, 0, 5'd0, 5'd0, 5'd0, 9'b100010000, 64'd0);
      vec("rp_reset", 1, 0, 0, 0, 0, 64'd0, 0, 5'd0, 5'd0, 5'd0, 9'b000000000, 64'd0);
      idle("rp_after");
      idle("rp_idle");

      @(posedge clk);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
